// File: rtl/mips_pc_sequencer.sv
// PC and fetch sequencer for MIPS_CORE: next-PC mux, run/halt/step FSM, retired count, self-loop stop.
// Latency: core outputs sampled at edge N set ReadAddr after edge N; backpressure: none, halt_req/step gate advances.
module mips_pc_sequencer #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 8'h00,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              halt_req,
  input  logic              step,
  input  logic [31:0]       SEImm,
  input  logic [25:0]       JumpValue,
  input  logic              Zero,
  input  logic              Branch,
  input  logic              Jump,
  output logic [ADDR_W-1:0] ReadAddr,
  output logic              Running,
  output logic              Halted,
  output logic              LoopHalt,
  output logic [CNT_W-1:0]  InstrCount
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t            state, nstate;
  logic              step_pend, nxt_pend;
  logic              advance, set_loop, clr_loop;
  logic [ADDR_W-1:0] pc4, next_pc;
  logic              self_loop;
  logic              unused_bits;

  assign unused_bits = ^{SEImm[31:ADDR_W-2], JumpValue[25:ADDR_W-2]};

  always_comb begin
    pc4 = ReadAddr + ADDR_W'(4);
    if (Jump)
      next_pc = {JumpValue[ADDR_W-3:0], 2'b00};
    else if (Branch && Zero)
      next_pc = pc4 + {SEImm[ADDR_W-3:0], 2'b00};
    else
      next_pc = pc4;
  end

  assign self_loop = (next_pc == ReadAddr);

  // A step pulse only arms step_pend; the advance itself happens on the following edge.
  always_comb begin
    nstate   = state;
    nxt_pend = 1'b0;
    advance  = 1'b0;
    set_loop = 1'b0;
    clr_loop = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (step_pend) begin
          advance = 1'b1;
          nstate  = HALTED;
        end else if (run && (state == IDLE || !halt_req)) begin
          nstate   = RUN;
          clr_loop = 1'b1;
        end else if (step) begin
          nxt_pend = 1'b1;
        end
      end
      RUN: begin
        if (halt_req) begin
          nstate = HALTED;
        end else if (self_loop) begin
          nstate   = HALTED;
          set_loop = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      step_pend  <= 1'b0;
      ReadAddr   <= RESET_ADDR;
      Running    <= 1'b0;
      Halted     <= 1'b0;
      LoopHalt   <= 1'b0;
      InstrCount <= '0;
    end else begin
      state     <= nstate;
      step_pend <= nxt_pend;
      Running   <= (nstate == RUN);
      Halted    <= (nstate == HALTED);
      if (advance) begin
        ReadAddr <= next_pc;
        if (InstrCount != {CNT_W{1'b1}})
          InstrCount <= InstrCount + CNT_W'(1);
      end
      if (set_loop)
        LoopHalt <= 1'b1;
      else if (clr_loop)
        LoopHalt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Directed table-driven bench for mips_pc_sequencer plus reset/idle hand sequences.
module tb_mips_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, halt_req, step;
  logic [31:0] SEImm;
  logic [25:0] JumpValue;
  logic        Zero, Branch, Jump;
  logic [7:0]  ReadAddr;
  logic        Running, Halted, LoopHalt;
  logic [15:0] InstrCount;

  int checks   = 0;
  int failures = 0;

  mips_pc_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .halt_req(halt_req), .step(step),
    .SEImm(SEImm), .JumpValue(JumpValue), .Zero(Zero), .Branch(Branch), .Jump(Jump),
    .ReadAddr(ReadAddr), .Running(Running), .Halted(Halted), .LoopHalt(LoopHalt),
    .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        run, halt_req, step, br, zero, jmp;
    logic [31:0] imm;
    logic [25:0] jv;
    logic [7:0]  e_pc;
    logic        e_run, e_halt, e_loop;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(input int r, input int h, input int s, input int br, input int z,
                              input int j, input int imm, input int jv, input int pc,
                              input int er, input int eh, input int el, input int cnt);
    vec_t x;
    x.run = r[0]; x.halt_req = h[0]; x.step = s[0];
    x.br = br[0]; x.zero = z[0]; x.jmp = j[0];
    x.imm = 32'(imm); x.jv = 26'(jv);
    x.e_pc = 8'(pc); x.e_run = er[0]; x.e_halt = eh[0]; x.e_loop = el[0]; x.e_cnt = 16'(cnt);
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t x);
    check({tag, ".ReadAddr"},   32'(ReadAddr),   32'(x.e_pc));
    check({tag, ".Running"},    32'(Running),    32'(x.e_run));
    check({tag, ".Halted"},     32'(Halted),     32'(x.e_halt));
    check({tag, ".LoopHalt"},   32'(LoopHalt),   32'(x.e_loop));
    check({tag, ".InstrCount"}, 32'(InstrCount), 32'(x.e_cnt));
  endtask

  task automatic apply(input vec_t x, input string tag);
    @(negedge clk);
    run = x.run; halt_req = x.halt_req; step = x.step;
    Branch = x.br; Zero = x.zero; Jump = x.jmp; SEImm = x.imm; JumpValue = x.jv;
    @(posedge clk);
    #1;
    check_outs(tag, x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    run = 1'b0; halt_req = 1'b0; step = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; halt_req = 1'b0; step = 1'b0;
    SEImm = '0; JumpValue = '0; Zero = 1'b0; Branch = 1'b0; Jump = 1'b0;
    #12;
    check_outs("reset", mk(0,0,0,0,0,0,0,0, 'h00,0,0,0,0));
    @(negedge clk);
    reset = 1'b0;

    //          run hlt stp br z  j  imm         jv          pc    run hlt lp cnt
    v.push_back(mk(1,  0,  0,  0, 0, 0, 0,          0,          'h00, 1,  0,  0, 0));
    v.push_back(mk(0,  0,  0,  0, 0, 0, 0,          0,          'h04, 1,  0,  0, 1));
    v.push_back(mk(0,  0,  0,  0, 0, 0, 0,          0,          'h08, 1,  0,  0, 2));
    v.push_back(mk(0,  0,  0,  0, 0, 0, 0,          0,          'h0C, 1,  0,  0, 3));
    v.push_back(mk(0,  0,  0,  0, 0, 0, 0,          0,          'h10, 1,  0,  0, 4));
    v.push_back(mk(0,  0,  0,  1, 1, 0, 'hFFFFFFFF, 0,          'h10, 0,  1,  1, 4));
    v.push_back(mk(1,  0,  0,  0, 0, 0, 0,          0,          'h10, 1,  0,  0, 4));
    v.push_back(mk(0,  0,  0,  1, 0, 0, 'hFFFFFFFF, 0,          'h14, 1,  0,  0, 5));
    v.push_back(mk(0,  0,  0,  0, 0, 0, 0,          0,          'h18, 1,  0,  0, 6));
    v.push_back(mk(0,  0,  0,  1, 1, 1, 0,          'h0100004,  'h10, 1,  0,  0, 7));
    v.push_back(mk(0,  0,  0,  1, 1, 0, 3,          0,          'h20, 1,  0,  0, 8));
    v.push_back(mk(0,  1,  0,  0, 0, 0, 0,          0,          'h20, 0,  1,  0, 8));
    v.push_back(mk(1,  1,  0,  0, 0, 0, 0,          0,          'h20, 0,  1,  0, 8));
    v.push_back(mk(0,  0,  1,  0, 0, 0, 0,          0,          'h20, 0,  1,  0, 8));
    v.push_back(mk(0,  0,  0,  0, 0, 0, 0,          0,          'h24, 0,  1,  0, 9));
    v.push_back(mk(0,  0,  0,  0, 0, 0, 0,          0,          'h24, 0,  1,  0, 9));
    v.push_back(mk(0,  0,  1,  0, 0, 0, 0,          0,          'h24, 0,  1,  0, 9));
    v.push_back(mk(0,  0,  0,  1, 1, 0, 'hFFFFFFFF, 0,          'h24, 0,  1,  0, 10));
    v.push_back(mk(1,  0,  0,  0, 0, 0, 0,          0,          'h24, 1,  0,  0, 10));
    v.push_back(mk(0,  0,  0,  0, 0, 1, 0,          'h3F,       'hFC, 1,  0,  0, 11));
    v.push_back(mk(0,  1,  0,  0, 0, 0, 0,          0,          'hFC, 0,  1,  0, 11));
    v.push_back(mk(0,  0,  1,  0, 0, 0, 0,          0,          'hFC, 0,  1,  0, 11));
    v.push_back(mk(0,  0,  0,  0, 0, 0, 0,          0,          'h00, 0,  1,  0, 12));
    v.push_back(mk(0,  0,  1,  0, 0, 0, 0,          0,          'h00, 0,  1,  0, 12));
    v.push_back(mk(0,  0,  0,  0, 0, 0, 0,          0,          'h04, 0,  1,  0, 13));
    v.push_back(mk(1,  0,  0,  0, 0, 0, 0,          0,          'h04, 1,  0,  0, 13));
    v.push_back(mk(0,  0,  0,  1, 1, 0, 'hFFFFFFFF, 0,          'h04, 0,  1,  1, 13));
    v.push_back(mk(0,  0,  1,  0, 0, 0, 0,          0,          'h04, 0,  1,  1, 13));
    v.push_back(mk(0,  0,  0,  0, 0, 0, 0,          0,          'h08, 0,  1,  1, 14));
    v.push_back(mk(1,  0,  0,  0, 0, 0, 0,          0,          'h08, 1,  0,  0, 14));

    for (int i = 0; i < v.size(); i++)
      apply(v[i], $sformatf("vec%0d", i));

    // Step out of IDLE: arm on one edge, advance on the next, land in HALTED.
    do_reset();
    apply(mk(0,0,1,0,0,0,0,0, 'h00,0,0,0,0), "idle_step_arm");
    apply(mk(0,0,0,0,0,0,0,0, 'h04,0,1,0,1), "idle_step_adv");

    // run and step together in IDLE: run wins.
    do_reset();
    apply(mk(1,0,1,0,0,0,0,0, 'h00,1,0,0,0), "run_step_both");
    apply(mk(0,0,0,0,0,0,0,0, 'h04,1,0,0,1), "run_adv1");
    apply(mk(0,0,0,0,0,0,0,0, 'h08,1,0,0,2), "run_adv2");

    // Asynchronous reset between edges while running.
    #2;
    reset = 1'b1;
    #1;
    check_outs("async_reset", mk(0,0,0,0,0,0,0,0, 'h00,0,0,0,0));
    @(posedge clk);
    #1;
    check_outs("reset_held", mk(0,0,0,0,0,0,0,0, 'h00,0,0,0,0));
    @(negedge clk);
    reset = 1'b0;
    apply(mk(0,0,0,0,0,0,0,0, 'h00,0,0,0,0), "post_reset1");
    apply(mk(0,0,0,0,0,0,0,0, 'h00,0,0,0,0), "post_reset2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
